mdu: RTL and testbench
======================

// Module: mdu
// PURPOSE
//  Iterative multiply/divide unit beside the ALU in the execute stage. Shares the ALU's
//  operand feed (rd1/rd2 from the register file) and owns the HI/LO registers for
//  MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
//  Radix-2 shift-add multiply and restoring divide take WIDTH+2 cycles per operation.
//  A start/busy/done handshake lets the controller stall while an operation runs.
// PARAMETERS
//  WIDTH   32   operand width; HI/LO are each WIDTH bits
//  CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      asynchronous reset, active-high
//  start   in   1      begin operation selected by op; accepted only when busy=0
//  op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rd1     in   WIDTH  multiplicand / dividend, sampled on the start edge
//  rd2     in   WIDTH  multiplier / divisor, sampled on the start edge
//  hi_we   in   1      MTHI: hi <= wdata (busy=0 only)
//  lo_we   in   1      MTLO: lo <= wdata (busy=0 only)
//  wdata   in   WIDTH  data for MTHI/MTLO
//  busy    out  1      operation in progress
//  done    out  1      one-cycle pulse: hi/lo hold a new result
//  hi      out  WIDTH  HI register (product upper half / remainder)
//  lo      out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//  Reset: busy=0, done=0, hi=0, lo=0, state=IDLE, counter=0. Reset is asynchronous.
//   Asserting rst mid-operation aborts it; no partial result reaches hi/lo.
//  States:
//   IDLE -(start)-> PREP -> RUN x WIDTH -> FIX -> IDLE
//   PREP: latch |rd1|, |rd2| and the result signs (signed ops); unsigned ops pass through.
//   RUN: one shift-add (mult) or shift-subtract/restore (div) step per cycle;
//    the counter runs 0..WIDTH-1.
//   FIX: apply sign correction. Write hi/lo at the FIX->IDLE edge. Pulse done the
//    following cycle.
//  Latency: start sampled at edge 0. busy=1 from edge 0 to edge WIDTH+2.
//   hi/lo update at edge WIDTH+2, when busy falls. done=1 for the cycle after edge WIDTH+2.
//  Back-to-back: start is accepted in the same cycle that done=1.
//  start while busy=1: ignored, with no queueing.
//  hi_we/lo_we while busy=1: dropped.
//  hi_we/lo_we with start in the same IDLE cycle: the write takes effect; the later
//   result overwrites it.
//  MULT/MULTU: {hi,lo} = full 2*WIDTH product, signed or unsigned.
//  DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, taking the dividend's sign.
//  Divide by zero, both signednesses: lo = all ones, hi = rd1. No trap.
//  DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0.
//  Operands are held internally, so rd1/rd2 may change freely after the start edge.
// STRUCTURE
//  mdu_pkg: op encodings MDU_MULT/MULTU/DIV/DIVU, state enum IDLE/PREP/RUN/FIX,
//   WIDTH default.
//  Sub-module mdu_step: combinational single iteration. Inputs are the partial
//   accumulator, the operand, and a mult/div select; outputs are the next accumulator
//   and the quotient bit.
//  mdu holds the FSM, counter, operand/sign registers and hi/lo.
// TESTING
//  1 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high 34 cycles;
//    one done pulse.
//  2 MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
//  3 DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//    DIVU 100/7 -> lo=14, hi=2.
//  4 DIVU 0x64/0 -> lo=0xFFFFFFFF, hi=0x64.
//    DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  5 Handshake/MTHI/MTLO:
//    - start again at cycle 5 of a MULT -> ignored; the result is unchanged.
//    - hi_we during busy -> hi unaffected.
//    - hi_we with wdata=0x1234 in IDLE -> hi=0x1234 next cycle.
//  6 rst at cycle 10 of a DIV -> busy=0, done=0, hi=lo=0 immediately.
//    A new MULTU 6*7 after release -> lo=42, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states and the default operand width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    RUN  = 2'b10,
    FIX  = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply,
// shift-subtract/restore for divide.
module mdu_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_hi,
  input  logic [W-1:0] i_lo,
  input  logic [W-1:0] i_opnd,
  input  logic         i_div,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo,
  output logic         o_q
);

  logic [W-1:0] w_add;
  logic [W:0]   w_sum;
  logic [W:0]   w_sh;

  always_comb begin
    w_add = i_lo[0] ? i_opnd : '0;
    w_sum = {1'b0, i_hi} + {1'b0, w_add};
    w_sh  = {i_hi, i_lo[W-1]};
    o_q   = 1'b0;
    o_hi  = w_sum[W:1];
    o_lo  = {w_sum[0], i_lo[W-1:1]};
    if (i_div) begin
      // remainder stays below the divisor, so W bits suffice
      o_q  = (w_sh >= {1'b0, i_opnd});
      o_hi = o_q ? (w_sh[W-1:0] - i_opnd)
                 : w_sh[W-1:0];
      o_lo = {i_lo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative MULT/DIV unit owning HI/LO.
// Operands are taken as magnitudes; signs are reapplied in FIX.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e r_state;
  mdu_state_e w_next;

  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_negq;
  logic               r_negr;
  logic               r_dz;
  logic               r_done;

  logic               w_sgn;
  logic               w_div;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic               w_q;
  logic [2*WIDTH-1:0] w_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_sgn = ~r_op[0];
  assign w_div = r_op[1];

  assign w_abs_a = (w_sgn && r_acc_lo[WIDTH-1])
                 ? -r_acc_lo : r_acc_lo;
  assign w_abs_b = (w_sgn && r_opnd[WIDTH-1])
                 ? -r_opnd : r_opnd;

  mdu_step #(.W(WIDTH)) u_step (
    .i_hi   (r_acc_hi),
    .i_lo   (r_acc_lo),
    .i_opnd (r_opnd),
    .i_div  (w_div),
    .o_hi   (w_step_hi),
    .o_lo   (w_step_lo),
    .o_q    (w_q)
  );

  // Divide by zero yields all-ones quotient; remainder is rd1.
  always_comb begin
    w_mag    = {r_acc_hi, r_acc_lo};
    w_prod   = r_negq ? -w_mag : w_mag;
    w_quo    = r_dz ? '1 : (r_negq ? -r_acc_lo : r_acc_lo);
    w_rem    = r_negr ? -r_acc_hi : r_acc_hi;
    w_res_hi = w_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_div ? w_quo : w_prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = PREP;
      PREP: w_next = RUN;
      RUN:  if (r_cnt == CNT_W'(WIDTH-1)) w_next = FIX;
      FIX:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = r_done;
    hi   = r_hi;
    lo   = r_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == FIX);
      unique case (r_state)
        IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_op     <= op;
            r_acc_lo <= rd1;
            r_opnd   <= rd2;
          end
        end
        PREP: begin
          r_acc_hi <= '0;
          r_cnt    <= '0;
          r_dz     <= (r_opnd == '0);
          r_negr   <= w_sgn & r_acc_lo[WIDTH-1];
          r_negq   <= w_sgn &
                      (r_acc_lo[WIDTH-1] ^ r_opnd[WIDTH-1]);
          if (w_div) begin
            r_opnd   <= w_abs_b;
            r_acc_lo <= w_abs_a;
          end else begin
            r_opnd   <= w_abs_a;
            r_acc_lo <= w_abs_b;
          end
        end
        RUN: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo |
                      {{(WIDTH-1){1'b0}}, w_q};
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table plus
// handshake, MTHI/MTLO and reset corner sequences.
module tb_mdu;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rd1 = '0;
  logic [W-1:0] rd2 = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .rd1   (rd1),
    .rd2   (rd2),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eh;
    logic [W-1:0] el;
  } vec_t;

  typedef struct {
    logic [W-1:0] h;
    logic [W-1:0] l;
  } res_t;

  res_t sb[$];
  vec_t tv[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   busy_n;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic model(input logic [1:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       output logic [W-1:0] eh,
                       output logic [W-1:0] el);
    longint      x;
    longint      y;
    logic [63:0] p;
    x = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
    y = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (!o[1]) begin
      p  = 64'(x * y);
      eh = p[63:32];
      el = p[31:0];
    end else if (b == '0) begin
      eh = a;
      el = '1;
    end else begin
      p  = 64'(x / y);
      el = p[31:0];
      p  = 64'(x % y);
      eh = p[31:0];
    end
  endtask

  // Starts at a negedge; returns at the negedge where done=1.
  task automatic run(input logic [1:0] o,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] eh,
                     input logic [W-1:0] el,
                     input bit inj);
    res_t r;
    bit   got;
    r.h = eh;
    r.l = el;
    sb.push_back(r);
    op    = o;
    rd1   = a;
    rd2   = b;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    hi_we  = 1'b0;
    rd1    = $urandom;
    rd2    = $urandom;
    busy_n = 0;
    got    = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (busy) busy_n++;
      if (done) got = 1'b1;
      else begin
        start = inj && (busy_n == 5);
        op    = MDU_DIVU;
        hi_we = inj && (busy_n == 7);
        wdata = 32'h0000DEAD;
        @(negedge clk);
      end
    end
    start = 1'b0;
    hi_we = 1'b0;
    if (!got) begin
      n_chk++;
      $display("FAIL timeout: no done within 100 cycles");
    end
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard: done with empty queue");
    end else begin
      r = sb.pop_front();
      chk("hi", hi, r.h);
      chk("lo", lo, r.l);
    end
    chk("busy_cycles", W'(busy_n), W'(W + 2));
  endtask

  initial begin
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [1:0]   ro;

    tv.push_back('{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFE, 32'h00000001});
    tv.push_back('{MDU_MULT, 32'hFFFFFFFD, 32'd7,
                   32'hFFFFFFFF, 32'hFFFFFFEB});
    tv.push_back('{MDU_DIV, 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFF, 32'hFFFFFFFD});
    tv.push_back('{MDU_DIVU, 32'd100, 32'd7,
                   32'd2, 32'd14});
    tv.push_back('{MDU_DIVU, 32'h64, 32'd0,
                   32'h64, 32'hFFFFFFFF});
    tv.push_back('{MDU_DIV, 32'h80000000, 32'hFFFFFFFF,
                   32'h0, 32'h80000000});
    tv.push_back('{MDU_DIV, 32'hFFFFFFF9, 32'd0,
                   32'hFFFFFFF9, 32'hFFFFFFFF});
    tv.push_back('{MDU_DIV, 32'd7, 32'hFFFFFFFE,
                   32'd1, 32'hFFFFFFFD});
    tv.push_back('{MDU_MULT, 32'h80000000, 32'h80000000,
                   32'h40000000, 32'h0});
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 0) ? 32'd0 : $urandom >> (i * 4);
      model(ro, ra, rb, eh, el);
      tv.push_back('{ro, ra, rb, eh, el});
    end

    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // back-to-back: each start lands on the done cycle
    foreach (tv[i])
      run(tv[i].op, tv[i].a, tv[i].b,
          tv[i].eh, tv[i].el, 1'b0);
    @(negedge clk);
    chk("done_pulse", W'(done), '0);
    chk("idle_busy", W'(busy), '0);

    run(MDU_MULT, 32'hFFFFFFFD, 32'd7,
        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);
    @(negedge clk);
    chk("no_queue_busy", W'(busy), '0);
    chk("busy_hi_we", hi, 32'hFFFFFFFF);

    hi_we = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", hi, 32'h1234);
    lo_we = 1'b1;
    wdata = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", lo, 32'h5678);
    chk("mtlo_hi_kept", hi, 32'h1234);

    hi_we = 1'b1;
    wdata = 32'hAAAA;
    run(MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    @(negedge clk);

    op    = MDU_DIV;
    rd1   = 32'd100;
    rd2   = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_hi", hi, '0);
    chk("abort_lo", lo, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_stays_idle", W'(busy), '0);
    run(MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
